// File: rtl/ap_mult_err_mon_pkg.sv
// ============================================================================
// ap_mult_err_mon_pkg : shared FSM encoding and default widths for the
//                       approximate-multiplier error monitor.
// Revision 1.0
// ============================================================================
`default_nettype none

package ap_mult_err_mon_pkg;

  localparam int c_DW_DEFAULT    = 12;
  localparam int c_RW_DEFAULT    = 2 * c_DW_DEFAULT;
  localparam int c_CNT_W_DEFAULT = 16;
  localparam int c_ACC_W_DEFAULT = 40;

  localparam int c_ST_W = 2;
  localparam logic [c_ST_W-1:0] c_IDLE  = 2'd0;
  localparam logic [c_ST_W-1:0] c_RUN   = 2'd1;
  localparam logic [c_ST_W-1:0] c_DRAIN = 2'd2;
  localparam logic [c_ST_W-1:0] c_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ap_err_dist.sv
// ============================================================================
// ap_err_dist : combinational unsigned distance |a-b| with a nonzero flag.
// Revision 1.0
// ============================================================================
`default_nettype none

module ap_err_dist
  import ap_mult_err_mon_pkg::*;
#(
  parameter int W = c_RW_DEFAULT
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] dist_o,
  output logic         is_err_o
);

  logic w_a_ge_b;

  assign w_a_ge_b = (a_i >= b_i);
  assign dist_o   = w_a_ge_b ? (a_i - b_i) : (b_i - a_i);
  assign is_err_o = (a_i != b_i);

endmodule

`default_nettype wire

// File: rtl/ap_mult_err_mon.sv
// ============================================================================
// ap_mult_err_mon : scores an approximate multiplier over a window of beats
//                   (error count, saturating ED sum, max ED).
// Revision 1.0
// ============================================================================
`default_nettype none

module ap_mult_err_mon
  import ap_mult_err_mon_pkg::*;
#(
  parameter int DW    = c_DW_DEFAULT,
  parameter int RW    = 2 * DW,
  parameter int CNT_W = c_CNT_W_DEFAULT,
  parameter int ACC_W = c_ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_samples_i,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic [DW-1:0]    muld_i,
  input  logic [DW-1:0]    mulr_i,
  input  logic [RW-1:0]    res_ap_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sample_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [ACC_W-1:0] sum_ed_o,
  output logic [RW-1:0]    max_ed_o
);

  logic [c_ST_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  acc_q;

  logic              s1_vld_q;
  logic [RW-1:0]     s1_exact_q;
  logic [RW-1:0]     s1_ap_q;

  logic [CNT_W-1:0]  sample_q;
  logic [CNT_W-1:0]  err_q;
  logic [ACC_W-1:0]  sum_q;
  logic [RW-1:0]     max_q;

  logic              w_start_ok;
  logic              w_accept;
  logic              w_last;
  logic [RW-1:0]     w_exact;
  logic [RW-1:0]     w_ed;
  logic              w_is_err;
  logic [ACC_W:0]    w_sum_ext;
  logic [ACC_W-1:0]  w_sum_sat;

  assign w_start_ok = (state_q == c_IDLE) && start_i;
  assign in_rdy_o   = (state_q == c_RUN);
  assign w_accept   = in_vld_i && in_rdy_o;
  assign w_last     = w_accept && ((acc_q + CNT_W'(1)) == n_q);

  // Operands are zero-extended so the product is formed at full RW width.
  assign w_exact = {{(RW-DW){1'b0}}, muld_i} * {{(RW-DW){1'b0}}, mulr_i};

  ap_err_dist #(
    .W (RW)
  ) u_err_dist (
    .a_i      (s1_exact_q),
    .b_i      (s1_ap_q),
    .dist_o   (w_ed),
    .is_err_o (w_is_err)
  );

  assign w_sum_ext = {1'b0, sum_q} + {{(ACC_W+1-RW){1'b0}}, w_ed};
  assign w_sum_sat = w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (start_i) begin
          state_d = (n_samples_i != '0) ? c_RUN : c_DONE;
        end
      end
      c_RUN: begin
        if (w_last) begin
          state_d = c_DRAIN;
        end
      end
      c_DRAIN: begin
        if (!s1_vld_q) begin
          state_d = c_DONE;
        end
      end
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_IDLE;
      n_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (w_start_ok) begin
        n_q   <= n_samples_i;
        acc_q <= '0;
      end else if (w_accept) begin
        acc_q <= acc_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_exact_q <= '0;
      s1_ap_q    <= '0;
    end else begin
      s1_vld_q <= w_accept;
      if (w_accept) begin
        s1_exact_q <= w_exact;
        s1_ap_q    <= res_ap_i;
      end
    end
  end

  // Start and accumulation never coincide: S1 is empty whenever the FSM is in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
      err_q    <= '0;
      sum_q    <= '0;
      max_q    <= '0;
    end else if (w_start_ok) begin
      sample_q <= '0;
      err_q    <= '0;
      sum_q    <= '0;
      max_q    <= '0;
    end else if (s1_vld_q) begin
      sample_q <= sample_q + CNT_W'(1);
      if (w_is_err) begin
        err_q <= err_q + CNT_W'(1);
      end
      sum_q <= w_sum_sat;
      if (w_ed > max_q) begin
        max_q <= w_ed;
      end
    end
  end

  assign busy_o       = (state_q == c_RUN) || (state_q == c_DRAIN);
  assign done_o       = (state_q == c_DONE);
  assign sample_cnt_o = sample_q;
  assign err_cnt_o    = err_q;
  assign sum_ed_o     = sum_q;
  assign max_ed_o     = max_q;

endmodule

`default_nettype wire

// File: tb/tb_ap_mult_err_mon.sv
// ============================================================================
// tb_ap_mult_err_mon : scoreboard bench for the approximate-multiplier monitor.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ap_mult_err_mon;

  localparam int DW    = 12;
  localparam int RW    = 24;
  localparam int CNT_W = 16;
  localparam int ACC_W = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [CNT_W-1:0] n_samples_i;
  logic             in_vld_i;
  logic             in_rdy_o;
  logic [DW-1:0]    muld_i;
  logic [DW-1:0]    mulr_i;
  logic [RW-1:0]    res_ap_i;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] sample_cnt_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [ACC_W-1:0] sum_ed_o;
  logic [RW-1:0]    max_ed_o;

  always #5 clk = ~clk;

  ap_mult_err_mon #(
    .DW    (DW),
    .RW    (RW),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .n_samples_i  (n_samples_i),
    .in_vld_i     (in_vld_i),
    .in_rdy_o     (in_rdy_o),
    .muld_i       (muld_i),
    .mulr_i       (mulr_i),
    .res_ap_i     (res_ap_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .sample_cnt_o (sample_cnt_o),
    .err_cnt_o    (err_cnt_o),
    .sum_ed_o     (sum_ed_o),
    .max_ed_o     (max_ed_o)
  );

  typedef struct {
    longint cnt;
    longint err;
    longint sum;
    longint mx;
  } stats_t;

  stats_t exp_q[$];
  int     checks    = 0;
  int     errors    = 0;
  int     done_seen = 0;
  logic   prev_done = 1'b0;

  // Directed beats used by mode 3.
  int dir_a[$];
  int dir_b[$];
  int dir_ap[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse consumes one expected window result.
  always @(negedge clk) begin : monitor
    stats_t e;
    if (!rst && done_o) begin
      done_seen++;
      chk("done_single_pulse", {63'd0, prev_done}, 64'd0);
      chk("busy_low_at_done", {63'd0, busy_o}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
      end else begin
        e = exp_q.pop_front();
        chk("sample_cnt", 64'(sample_cnt_o), 64'(e.cnt));
        chk("err_cnt",    64'(err_cnt_o),    64'(e.err));
        chk("sum_ed",     64'(sum_ed_o),     64'(e.sum));
        chk("max_ed",     64'(max_ed_o),     64'(e.mx));
      end
    end
    prev_done = done_o;
  end

  // mode 0: exact results, 2: random mix of errors, 3: directed beats.
  task automatic run_window(input int n, input int mode, input int gap_pct,
                            input int extra, input bit inject_start);
    int     qa[$];
    int     qb[$];
    int     qap[$];
    stats_t e;
    longint prod, ed;
    int     a, b, ap, r, idx, budget, ds0;
    bit     take;
    e.cnt = n; e.err = 0; e.sum = 0; e.mx = 0;
    for (int i = 0; i < n; i++) begin
      if (mode == 3) begin
        a = dir_a[i]; b = dir_b[i]; ap = dir_ap[i];
      end else begin
        a = int'($urandom_range(4095));
        b = int'($urandom_range(4095));
        prod = longint'(a) * longint'(b);
        r = int'($urandom_range(3));
        if (mode == 0 || r == 0) ap = int'(prod);
        else if (r == 1)         ap = int'($urandom_range(24'hFFFFFF));
        else if (r == 2)         ap = int'(prod) ^ int'($urandom_range(7));
        else                     ap = int'(prod) + 1;
      end
      qa.push_back(a); qb.push_back(b); qap.push_back(ap);
      prod = longint'(a) * longint'(b);
      ed   = (prod >= longint'(ap)) ? prod - longint'(ap) : longint'(ap) - prod;
      if (ed != 0) e.err++;
      e.sum += ed;
      if (e.sum > 64'hFF_FFFF_FFFF) e.sum = 64'hFF_FFFF_FFFF;
      if (ed > e.mx) e.mx = ed;
    end
    exp_q.push_back(e);
    ds0 = done_seen;

    @(negedge clk);
    start_i     = 1'b1;
    n_samples_i = CNT_W'(n);
    @(negedge clk);
    start_i = 1'b0;
    if (n == 0) begin
      #2;
      chk("n0_done_next_cycle", 64'(done_seen - ds0), 64'd1);
    end else begin
      chk("busy_after_start", {63'd0, busy_o}, 64'd1);
    end

    idx = 0;
    budget = 0;
    while (idx < n && budget < 2000) begin
      in_vld_i = (int'($urandom_range(99)) >= gap_pct);
      muld_i   = DW'(qa[idx]);
      mulr_i   = DW'(qb[idx]);
      res_ap_i = RW'(qap[idx]);
      if (inject_start && idx == 1) begin
        start_i     = 1'b1;
        n_samples_i = CNT_W'(7);
      end
      #1;
      take = in_vld_i && in_rdy_o;
      @(posedge clk);
      if (take) idx++;
      @(negedge clk);
      start_i = 1'b0;
      budget++;
    end
    in_vld_i = 1'b0;
    if (budget >= 2000) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got %0d beats accepted, expected %0d", idx, n);
    end
    if (n > 0) chk("in_rdy_low_after_last", {63'd0, in_rdy_o}, 64'd0);

    for (int k = 0; k < extra; k++) begin
      in_vld_i = 1'b1;
      muld_i   = DW'($urandom);
      mulr_i   = DW'($urandom);
      res_ap_i = RW'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("in_rdy_low_tail", {63'd0, in_rdy_o}, 64'd0);
    end
    in_vld_i = 1'b0;

    budget = 0;
    while (done_seen == ds0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (done_seen == ds0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected one within 50 cycles");
      void'(exp_q.pop_back());
    end
    repeat (2) @(negedge clk);
    chk("stats_hold_cnt", 64'(sample_cnt_o), 64'(e.cnt));
    chk("stats_hold_sum", 64'(sum_ed_o), 64'(e.sum));
  endtask

  initial begin : stim
    rst         = 1'b1;
    start_i     = 1'b0;
    n_samples_i = '0;
    in_vld_i    = 1'b0;
    muld_i      = '0;
    mulr_i      = '0;
    res_ap_i    = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {63'd0, busy_o},   64'd0);
    chk("rst_done",   {63'd0, done_o},   64'd0);
    chk("rst_in_rdy", {63'd0, in_rdy_o}, 64'd0);
    chk("rst_cnt",    64'(sample_cnt_o), 64'd0);
    chk("rst_err",    64'(err_cnt_o),    64'd0);
    chk("rst_sum",    64'(sum_ed_o),     64'd0);
    chk("rst_max",    64'(max_ed_o),     64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_window(4, 0, 0, 0, 1'b0);

    dir_a = '{4095}; dir_b = '{4095}; dir_ap = '{0};
    run_window(1, 3, 0, 0, 1'b0);

    dir_a = '{10, 5}; dir_b = '{10, 10}; dir_ap = '{90, 60};
    run_window(2, 3, 0, 0, 1'b0);

    run_window(3, 2, 50, 2, 1'b0);

    // Asynchronous reset in the middle of a window.
    @(negedge clk);
    start_i     = 1'b1;
    n_samples_i = CNT_W'(5);
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_vld_i = 1'b1;
      muld_i   = DW'($urandom);
      mulr_i   = DW'($urandom);
      res_ap_i = RW'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    in_vld_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy",   {63'd0, busy_o},   64'd0);
    chk("midrst_in_rdy", {63'd0, in_rdy_o}, 64'd0);
    chk("midrst_cnt",    64'(sample_cnt_o), 64'd0);
    chk("midrst_err",    64'(err_cnt_o),    64'd0);
    chk("midrst_sum",    64'(sum_ed_o),     64'd0);
    chk("midrst_max",    64'(max_ed_o),     64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_done", {63'd0, done_o}, 64'd0);

    run_window(1, 2, 0, 0, 1'b0);
    run_window(0, 2, 0, 0, 1'b0);
    run_window(5, 2, 20, 1, 1'b1);

    for (int w = 0; w < 12; w++) begin
      run_window(int'($urandom_range(20, 1)), 2, 30,
                 int'($urandom_range(2)), 1'($urandom_range(1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
